// File: rtl/test_master_slave_multi_pkg.sv
// Shared types and width helpers for the multi-channel master-slave collector.
package testmasterslavemulti_types;

  typedef enum logic {
    section_a = 1'b0,
    section_b = 1'b1
  } Sections;

  // Accumulator width: wide enough for NUM_CH full-scale signed samples.
  function automatic int acc_width(input int num_ch, input int data_w);
    if (num_ch <= 1) return data_w;
    return data_w + $clog2(num_ch);
  endfunction

  function automatic int idx_width(input int num_ch);
    if (num_ch <= 1) return 1;
    return $clog2(num_ch);
  endfunction

endpackage

// File: rtl/test_master_slave_multi_channel_mux.sv
// Selects the polled channel's sample and sync flag; sample is sign-extended to ACC_W.
module tms_channel_mux
  import testmasterslavemulti_types::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = acc_width(NUM_CH, DATA_W),
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH*DATA_W-1:0] s_in,
  input  logic [NUM_CH-1:0]        s_in_sync,
  input  logic [IDX_W-1:0]         ch_idx,
  output logic [ACC_W-1:0]         sample,
  output logic                     sync
);

  logic signed [DATA_W-1:0] lane [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      assign lane[gi] = s_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Compare-based select keeps out-of-range indices harmless for non-power-of-2 NUM_CH.
  always_comb begin
    sample = '0;
    sync   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_idx == IDX_W'(k)) begin
        sample = ACC_W'(lane[k]);
        sync   = s_in_sync[k];
      end
    end
  end

endmodule

// File: rtl/test_master_slave_multi.sv
// Round-robin collector: sums one sample per channel, publishes the round sum with a strobe.
// Optional per-channel idle timeout/skip is enabled by defining TMS_SKIP_TIMEOUT_EN.
module test_master_slave_multi
  import testmasterslavemulti_types::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  DATA_W  = 32,
  parameter int  TIMEOUT = 8,
  localparam int ACC_W   = acc_width(NUM_CH, DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] s_in,
  input  logic [NUM_CH-1:0]        s_in_sync,
  output logic [ACC_W-1:0]         m_out,
  output logic                     m_out_valid,
  output logic [NUM_CH-1:0]        m_skip_mask,
  output Sections                  section_o
);

  localparam int               IDX_W   = idx_width(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  if (NUM_CH < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("test_master_slave_multi: NUM_CH and TIMEOUT must be >= 1");
  end

  Sections                   section_reg, section_next;
  logic [IDX_W-1:0]          ch_idx_reg, ch_idx_next;
  logic signed [ACC_W-1:0]   acc_reg, acc_next;
  logic [ACC_W-1:0]          m_out_reg, m_out_next;
  logic                      m_out_valid_reg, m_out_valid_next;
  logic                      advance;
  logic [ACC_W-1:0]          sample;
  logic                      sync;

`ifdef TMS_SKIP_TIMEOUT_EN
  localparam int               TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [NUM_CH-1:0]  skip_reg, skip_next;
  logic [NUM_CH-1:0]  m_skip_mask_reg, m_skip_mask_next;
`endif

  tms_channel_mux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .IDX_W  (IDX_W)
  ) u_mux (
    .s_in      (s_in),
    .s_in_sync (s_in_sync),
    .ch_idx    (ch_idx_reg),
    .sample    (sample),
    .sync      (sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_reg     <= section_a;
      ch_idx_reg      <= '0;
      acc_reg         <= '0;
      m_out_reg       <= '0;
      m_out_valid_reg <= 1'b0;
`ifdef TMS_SKIP_TIMEOUT_EN
      timer_reg       <= '0;
      skip_reg        <= '0;
      m_skip_mask_reg <= '0;
`endif
    end else begin
      section_reg     <= section_next;
      ch_idx_reg      <= ch_idx_next;
      acc_reg         <= acc_next;
      m_out_reg       <= m_out_next;
      m_out_valid_reg <= m_out_valid_next;
`ifdef TMS_SKIP_TIMEOUT_EN
      timer_reg       <= timer_next;
      skip_reg        <= skip_next;
      m_skip_mask_reg <= m_skip_mask_next;
`endif
    end
  end

  always_comb begin
    section_next     = section_reg;
    ch_idx_next      = ch_idx_reg;
    acc_next         = acc_reg;
    m_out_next       = m_out_reg;
    m_out_valid_next = 1'b0;
    advance          = 1'b0;
`ifdef TMS_SKIP_TIMEOUT_EN
    timer_next       = timer_reg;
    skip_next        = skip_reg;
    m_skip_mask_next = m_skip_mask_reg;
`endif
    case (section_reg)
      section_a: begin
        // A sync arriving on the expiry cycle takes priority over the skip.
        if (sync) begin
          acc_next = acc_reg + signed'(sample);
          advance  = 1'b1;
        end
`ifdef TMS_SKIP_TIMEOUT_EN
        else if (timer_reg == TIMER_LAST) begin
          skip_next[ch_idx_reg] = 1'b1;
          advance               = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
        if (advance) timer_next = '0;
`endif
        if (advance) begin
          if (ch_idx_reg == LAST_CH) section_next = section_b;
          else                       ch_idx_next  = ch_idx_reg + 1'b1;
        end
      end
      section_b: begin
        m_out_next       = acc_reg;
        m_out_valid_next = 1'b1;
        acc_next         = '0;
        ch_idx_next      = '0;
        section_next     = section_a;
`ifdef TMS_SKIP_TIMEOUT_EN
        m_skip_mask_next = skip_reg;
        skip_next        = '0;
        timer_next       = '0;
`endif
      end
    endcase
  end

  assign m_out       = m_out_reg;
  assign m_out_valid = m_out_valid_reg;
  assign section_o   = section_reg;
`ifdef TMS_SKIP_TIMEOUT_EN
  assign m_skip_mask = m_skip_mask_reg;
`else
  assign m_skip_mask = '0;
`endif

endmodule

// File: tb/tb_test_master_slave_multi.sv
// Scoreboard bench for test_master_slave_multi: rounds are issued as transactions, sums checked on strobe.
module tb_test_master_slave_multi;
  import testmasterslavemulti_types::*;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int ACC_W   = 34;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH*DATA_W-1:0] s_in = '0;
  logic [NUM_CH-1:0]        s_in_sync = '0;
  logic [ACC_W-1:0]         m_out;
  logic                     m_out_valid;
  logic [NUM_CH-1:0]        m_skip_mask;
  Sections                  section_o;

  always #5 clk = ~clk;

  test_master_slave_multi #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_in        (s_in),
    .s_in_sync   (s_in_sync),
    .m_out       (m_out),
    .m_out_valid (m_out_valid),
    .m_skip_mask (m_skip_mask),
    .section_o   (section_o)
  );

  typedef struct {
    logic [ACC_W-1:0]  sum;
    logic [NUM_CH-1:0] mask;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          strobe_t[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  bit          force_others = 1'b0;
  logic [31:0] rv[NUM_CH];
  int          rd[NUM_CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One input cycle: random traffic everywhere, channel k overridden; returns at next negedge.
  task automatic drive_cycle(input int k, input bit sync_k, input logic [31:0] val);
    logic [NUM_CH*DATA_W-1:0] d;
    logic [NUM_CH-1:0]        s;
    d = {$urandom, $urandom, $urandom, $urandom};
    s = 4'($urandom);
    if (force_others) s = '1;
    if (k >= 0) begin
      d[k*DATA_W +: DATA_W] = val;
      s[k]                  = sync_k;
    end
    s_in      = d;
    s_in_sync = s;
    @(negedge clk);
  endtask

  // Reference: the round sum is the plain signed sum of accepted samples; a skipped channel adds 0.
  task automatic run_round();
    longint            sum  = 0;
    logic [NUM_CH-1:0] mask = '0;
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef TMS_SKIP_TIMEOUT_EN
      if (rd[k] >= TIMEOUT) begin
        repeat (TIMEOUT) drive_cycle(k, 1'b0, $urandom);
        mask[k] = 1'b1;
        continue;
      end
`endif
      repeat (rd[k]) drive_cycle(k, 1'b0, $urandom);
      drive_cycle(k, 1'b1, rv[k]);
      sum += longint'(signed'(rv[k]));
    end
    exp_q.push_back('{ACC_W'(sum), mask});
    drive_cycle(-1, 1'b0, 32'h0);
  endtask

  task automatic set_vals(input logic [31:0] a, b, c, d);
    rv[0] = a; rv[1] = b; rv[2] = c; rv[3] = d;
  endtask

  task automatic set_dly(input int a, b, c, d);
    rd[0] = a; rd[1] = b; rd[2] = c; rd[3] = d;
  endtask

  always @(negedge clk) begin
    if (!rst && m_out_valid) begin
      strobe_t.push_back(cyc - rel_cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got m_out=%0d, required no strobe",
                 longint'(signed'(m_out)));
      end else begin
        mon_e = exp_q.pop_front();
        check("round_sum", longint'(signed'(m_out)), longint'(signed'(mon_e.sum)));
        check("skip_mask", longint'(m_skip_mask), longint'(mon_e.mask));
        $display("round: m_out=%0d mask=%b", longint'(signed'(m_out)), m_skip_mask);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_m_out", longint'(m_out), 0);
    check("reset_valid", longint'(m_out_valid), 0);
    check("reset_mask", longint'(m_skip_mask), 0);
    check("reset_section", longint'(section_o), longint'(section_a));
    rst     = 1'b0;
    rel_cyc = cyc;

    // Back-to-back full-speed rounds, then a round with ch1 late and spurious syncs elsewhere.
    set_vals(32'd1, 32'd2, 32'd3, 32'd4);
    set_dly(0, 0, 0, 0);
    run_round();
    run_round();
    force_others = 1'b1;
    set_dly(0, 3, 0, 0);
    run_round();
    force_others = 1'b0;

    set_vals(32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFF9, 32'd1);
    set_dly(0, 0, 0, 0);
    run_round();
    if (strobe_t.size() < 3) begin
      total++;
      bad++;
      $display("FAIL strobe_count: got %0d, required at least 3", strobe_t.size());
    end else begin
      check("first_strobe_cycle", strobe_t[0], 5);
      check("strobe_period", strobe_t[1] - strobe_t[0], 5);
      check("delayed_period", strobe_t[2] - strobe_t[1], 8);
    end

    set_vals(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_round();
    set_vals(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_round();

    set_vals(32'd10, 32'd20, 32'd30, 32'd40);
`ifdef TMS_SKIP_TIMEOUT_EN
    set_dly(0, 0, 50, 0);
    run_round();
    set_dly(0, 0, TIMEOUT - 1, 0);
    run_round();
    set_dly(0, 0, TIMEOUT, 0);
    run_round();
`else
    set_dly(0, 0, 100, 0);
    run_round();
`endif

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        case ($urandom_range(0, 5))
          0:       rv[k] = 32'h7FFF_FFFF;
          1:       rv[k] = 32'h8000_0000;
          default: rv[k] = $urandom;
        endcase
`ifdef TMS_SKIP_TIMEOUT_EN
        rd[k] = $urandom_range(0, TIMEOUT + 2);
`else
        rd[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : 0;
`endif
      end
      force_others = ($urandom_range(0, 1) == 1);
      run_round();
    end
    force_others = 1'b0;

    // Reset in the middle of a round: partial sum must vanish without a strobe.
    set_vals(32'd9, 32'd9, 32'd9, 32'd9);
    drive_cycle(0, 1'b1, rv[0]);
    drive_cycle(1, 1'b1, rv[1]);
    rst = 1'b1;
    #1;
    check("midreset_m_out", longint'(m_out), 0);
    check("midreset_valid", longint'(m_out_valid), 0);
    check("midreset_mask", longint'(m_skip_mask), 0);
    check("midreset_section", longint'(section_o), longint'(section_a));
    s_in_sync = '0;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    rel_cyc = cyc;
    set_vals(32'd1, 32'd1, 32'd1, 32'd1);
    set_dly(0, 0, 0, 0);
    run_round();

    s_in_sync = '0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
